// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   uart_rx_state_e  : receiver FSM states
//   UART_DATA_W      : payload bits per frame
//   UART_SYNC_STAGES : flops in the rx input synchronizer
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received bytes.
// Ports:
//   clk, srst        : clock, synchronous active-high reset
//   push, push_data  : write request and byte (dropped when full unless popping)
//   pop              : read strobe; ignored when empty
//   rd_data          : registered head entry, valid while !empty
//   count            : entries held (0..DEPTH)
//   full, empty      : occupancy flags derived from count
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             pop_eff;
    logic             push_eff;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CW'(DEPTH));
    // A pop frees the slot a full-FIFO push needs, so both may proceed.
    assign pop_eff    = pop & ~empty;
    assign push_eff   = push & (~full | pop_eff);
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_eff)  rd_ptr_reg <= rd_ptr_inc;
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head register: loaded directly on a push into an empty FIFO; on a pop
    // it takes the next stored entry, or the byte being pushed right now when
    // the popped entry was the only one.
    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg <= '0;
        end else if (empty && push_eff) begin
            head_reg <= push_data;
        end else if (pop_eff) begin
            head_reg <= (count_reg == CW'(1)) ? push_data : mem[rd_ptr_inc];
        end
    end

    assign rd_data = head_reg;
    assign count   = count_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver (8N1, LSB first) feeding a FWFT receive FIFO.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit, parity_err_o).
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   rx_i               : asynchronous serial input, idle high
//   rd_en_i            : FIFO pop strobe (ignored when empty)
//   clr_err_i          : clears sticky error flags (a same-cycle set wins)
//   rd_data_o          : FIFO head byte, valid while rx_valid_o
//   rx_valid_o         : FIFO not empty
//   fifo_count_o       : entries held
//   overrun_o          : sticky, byte dropped on full FIFO
//   frame_err_o        : sticky, stop bit sampled low
//   irq_o              : OR of rx_valid_o and the sticky error flags
//   parity_err_o       : sticky parity mismatch (UART_RX_PARITY_EN only)
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    input  logic                          rd_en_i,
    input  logic                          clr_err_i,
    output logic [UART_DATA_W-1:0]        rd_data_o,
    output logic                          rx_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overrun_o,
    output logic                          frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err_o,
`endif
    output logic                          irq_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    // Input synchronizer, preset to the idle level so reset never looks
    // like a start bit.
    logic [UART_SYNC_STAGES-1:0] sync_reg;
    logic                        rx_s;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) sync_reg[0] <= 1'b1;
        else          sync_reg[0] <= rx_i;
    end

    generate
        for (genvar gi = 1; gi < UART_SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) sync_reg[gi] <= 1'b1;
                else          sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    assign rx_s = sync_reg[UART_SYNC_STAGES-1];

    uart_rx_state_e           state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [2:0]               bit_idx_reg, bit_idx_next;
    logic [UART_DATA_W-1:0]   shift_reg, shift_next;
    logic                     cnt_done;
    logic                     byte_push;
    logic                     ferr_set;
`ifdef UART_RX_PARITY_EN
    logic                     par_bad_reg, par_bad_next;
    logic                     perr_set;
    logic                     parity_err_reg;
`endif

    assign cnt_done = (cnt_reg == '0);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_done ? cnt_reg : cnt_reg - CNT_W'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        byte_push    = 1'b0;
        ferr_set     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad_reg;
        perr_set     = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                cnt_next = HALF_M1;
                if (!rx_s) state_next = ST_START;
            end
            ST_START: begin
                if (cnt_done) begin
                    cnt_next     = FULL_M1;
                    bit_idx_next = 3'd0;
                    state_next   = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_done) begin
                    shift_next[bit_idx_reg] = rx_s;
                    cnt_next                = FULL_M1;
                    bit_idx_next            = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_done) begin
                    // Even parity: data bits plus parity bit XOR to zero.
                    par_bad_next = (^shift_reg) ^ rx_s;
                    perr_set     = (^shift_reg) ^ rx_s;
                    cnt_next     = FULL_M1;
                    state_next   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_done) begin
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        byte_push = ~par_bad_reg;
`else
                        byte_push = 1'b1;
`endif
                        state_next = ST_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold here while the line stays low so a break is not
                // decoded as a stream of 0x00 bytes.
                if (rx_s) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= par_bad_next;
`endif
        end
    end

    logic fifo_full;
    logic fifo_empty;
    logic ovr_set;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .push      (byte_push),
        .push_data (shift_reg),
        .pop       (rd_en_i),
        .rd_data   (rd_data_o),
        .count     (fifo_count_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A pop on a full FIFO always succeeds, making room for the push.
    assign ovr_set = byte_push & fifo_full & ~rd_en_i;

    logic overrun_reg;
    logic frame_err_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            overrun_reg   <= ovr_set  | (overrun_reg   & ~clr_err_i);
            frame_err_reg <= ferr_set | (frame_err_reg & ~clr_err_i);
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= perr_set | (parity_err_reg & ~clr_err_i);
`endif
        end
    end

    assign rx_valid_o  = ~fifo_empty;
    assign overrun_o   = overrun_reg;
    assign frame_err_o = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_reg;
    assign irq_o        = rx_valid_o | overrun_reg | frame_err_reg | parity_err_reg;
`else
    assign irq_o        = rx_valid_o | overrun_reg | frame_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed serial frames, a transaction-level
// model (byte queue + sticky flags) checked every cycle, plus literal
// expectations at key points.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;
    localparam int DEP = 4;
    // Cycles from the edge that drives the start bit low to the edge where
    // the received byte becomes visible: 2 synchronizer cycles, half a bit
    // to the start centre, 9 bits to the stop centre, 1 registration cycle.
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       frame_err;
    logic       irq;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEP)
    ) dut (
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parity_err),
`endif
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .rx_i         (rx),
        .rd_en_i      (rd_en),
        .clr_err_i    (clr),
        .rd_data_o    (rd_data),
        .rx_valid_o   (rx_valid),
        .fifo_count_o (fifo_count),
        .overrun_o    (overrun),
        .frame_err_o  (frame_err),
        .irq_o        (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    // Model: expected FIFO contents, sticky flags, scheduled frame outcomes.
    typedef struct {
        int         at;
        bit         ferr;
        logic [7:0] d;
    } ev_t;
    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit         pushv;
        bit         fe;
        bit         so;
        logic [7:0] d;
        cyc++;
        if (rst) begin
            mq.delete();
            evq.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            return;
        end
        pushv = 1'b0;
        fe    = 1'b0;
        so    = 1'b0;
        d     = 8'h00;
        if (evq.size() > 0 && evq[0].at == cyc) begin
            if (evq[0].ferr) fe = 1'b1;
            else begin
                pushv = 1'b1;
                d     = evq[0].d;
            end
            void'(evq.pop_front());
        end
        if (rd_en && mq.size() > 0) void'(mq.pop_front());
        if (pushv) begin
            if (mq.size() < DEP) mq.push_back(d);
            else so = 1'b1;
        end
        m_ovr  = so ? 1'b1 : (clr ? 1'b0 : m_ovr);
        m_ferr = fe ? 1'b1 : (clr ? 1'b0 : m_ferr);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            logic [14:0] act;
            logic [14:0] exp;
            bit          ne;
            ne  = (mq.size() != 0);
            exp = {ne, 3'(mq.size()), m_ovr, m_ferr, (ne | m_ovr | m_ferr),
                   ne ? mq[0] : 8'h00};
            act = {rx_valid, fifo_count, overrun, frame_err, irq,
                   ne ? rd_data : 8'h00};
            chk($sformatf("cycle{valid,count,ovr,ferr,irq,data}"), int'(act), int'(exp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int extra_low);
        tick();
        rx = 1'b0;
        evq.push_back('{cyc + LAT, !stop, d});
        $display("send byte 0x%02h stop=%0b at cycle %0d", d, stop, cyc);
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
        if (!stop) repeat (extra_low) tick();
        rx = 1'b1;
    endtask

    task automatic pop_exp(input logic [7:0] e);
        @(negedge clk);
        chk("pop_head_valid", int'(rx_valid), 1);
        chk("pop_head_data", int'(rd_data), int'(e));
        $display("pop byte 0x%02h (expected 0x%02h)", rd_data, e);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_data", int'(rd_data), 0);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_flags", int'({overrun, frame_err, irq}), 0);

        // Single byte with exact latency of rx_valid.
        fork
            send_byte(8'h3D, 1'b1, 0);
            begin
                tick();
                t0 = cyc;
                repeat (LAT - 1) @(posedge clk);
                @(negedge clk);
                chk("latency_valid_before", int'(rx_valid), 0);
                @(negedge clk);
                chk("latency_valid_at", int'(rx_valid), 1);
                chk("first_byte_data", int'(rd_data), 8'h3D);
                chk("first_byte_count", int'(fifo_count), 1);
                chk("first_byte_irq", int'(irq), 1);
            end
        join
        pop_exp(8'h3D);
        @(negedge clk);
        chk("after_pop_valid", int'(rx_valid), 0);

        // Back-to-back bytes fill the FIFO exactly.
        send_byte(8'h0F, 1'b1, 0);
        send_byte(8'hA5, 1'b1, 0);
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        @(negedge clk);
        chk("four_count", int'(fifo_count), 4);
        pop_exp(8'h0F);
        pop_exp(8'hA5);
        pop_exp(8'hFF);
        pop_exp(8'h00);
        @(negedge clk);
        chk("drained_count", int'(fifo_count), 0);

        // Overrun: fifth byte dropped.
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 0);
        send_byte(8'h33, 1'b1, 0);
        send_byte(8'h44, 1'b1, 0);
        send_byte(8'h55, 1'b1, 0);
        @(negedge clk);
        chk("ovr_count", int'(fifo_count), 4);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_irq", int'(irq), 1);
        pulse_clr();
        @(negedge clk);
        chk("ovr_cleared", int'(overrun), 0);
        pop_exp(8'h11);
        pop_exp(8'h22);
        pop_exp(8'h33);
        pop_exp(8'h44);

        // Glitch: 7 cycles low is rejected at the start-bit centre.
        tick();
        rx = 1'b0;
        repeat (7) tick();
        rx = 1'b1;
        $display("glitch 7 cycles low at cycle %0d", cyc);
        repeat (3 * CPB) tick();
        @(negedge clk);
        chk("glitch_count", int'(fifo_count), 0);
        chk("glitch_flags", int'({overrun, frame_err, irq}), 0);

        // Stop bit low, line held low: one frame error, no 0x00 bytes.
        send_byte(8'h00, 1'b0, 40);
        repeat (10) tick();
        @(negedge clk);
        chk("ferr_flag", int'(frame_err), 1);
        chk("ferr_count", int'(fifo_count), 0);
        chk("ferr_irq", int'(irq), 1);
        send_byte(8'h55, 1'b1, 0);
        @(negedge clk);
        chk("after_break_data", int'(rd_data), 8'h55);
        chk("after_break_count", int'(fifo_count), 1);

        // Reset in the data phase of 0x3D; only 0x61 survives afterwards.
        tick();
        rx = 1'b0;
        $display("partial byte 0x3D then reset at cycle %0d", cyc);
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (CPB) tick();
        rx = 1'b0;
        repeat (CPB / 2) tick();
        rx = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_count", int'(fifo_count), 0);
        chk("rst_mid_flags", int'({overrun, frame_err, irq}), 0);
        repeat (2 * CPB) tick();
        send_byte(8'h61, 1'b1, 0);
        @(negedge clk);
        chk("post_rst_data", int'(rd_data), 8'h61);
        chk("post_rst_count", int'(fifo_count), 1);
        chk("post_rst_flags", int'({overrun, frame_err}), 0);
        pop_exp(8'h61);

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
